// File: rtl/seg7_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_mux : 8-digit common-anode scan driver with blink and DP masks.   |
// | Optional macro SEG7_GHOST_BLANK_EN blanks each slot for BLANK_CYCLES.      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module seg7_scan_mux #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 62,
   parameter int BLANK_CYCLES = 200
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        enable,
   input  logic [55:0] seg7_in,
   input  logic [7:0]  blink_mask,
   input  logic [7:0]  dp_mask,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_start
);

   localparam int SW = $clog2(REFRESH_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [SW-1:0] c_SLOT_LAST  = SW'(REFRESH_DIV - 1);
   localparam logic [FW-1:0] c_FRAME_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [SW-1:0] c_BLANK      = SW'(BLANK_CYCLES);
`ifdef SEG7_GHOST_BLANK_EN
   localparam logic c_GHOST_EN = 1'b1;
`else
   localparam logic c_GHOST_EN = 1'b0;
`endif

   logic [SW-1:0] slot_q, slot_d;
   logic [2:0]    idx_q, idx_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          blink_q, blink_d;
   logic          wrap_q, wrap_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          fs_q, fs_d;

   logic          slot_wrap;
   logic          idx_wrap;
   logic          frame_wrap;
   logic          hide;
   logic          drive;
   logic [6:0]    cur_seg;

   always_comb begin
      slot_wrap  = (slot_q == c_SLOT_LAST);
      idx_wrap   = slot_wrap && (idx_q == 3'd7);
      frame_wrap = idx_wrap && (frame_q == c_FRAME_LAST);

      slot_d  = slot_wrap ? '0 : slot_q + SW'(1);
      idx_d   = slot_wrap ? idx_q + 3'd1 : idx_q;
      frame_d = frame_q;
      if (idx_wrap) begin
         frame_d = frame_wrap ? '0 : frame_q + FW'(1);
      end
      blink_d = blink_q ^ frame_wrap;

      // Wrap is delayed one stage so the pulse lines up with digit 0 on the outputs.
      wrap_d = idx_wrap;
      fs_d   = wrap_q;

      cur_seg = seg7_in[7*int'(idx_q) +: 7];
      hide    = blink_q && blink_mask[idx_q];
      drive   = enable && !(c_GHOST_EN && (slot_q < c_BLANK));

      an_d  = drive ? ~(8'd1 << idx_q) : 8'hFF;
      seg_d = (drive && !hide) ? cur_seg : 7'h7F;
      dp_d  = ~(drive && dp_mask[idx_q] && !hide);
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         slot_q  <= '0;
         idx_q   <= 3'd0;
         frame_q <= '0;
         blink_q <= 1'b0;
         wrap_q  <= 1'b0;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         blink_q <= blink_d;
         wrap_q  <= wrap_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         fs_q    <= fs_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// Bench for seg7_scan_mux: directed literal pins plus randomized run against
// a cycle-position model of the scan sequence.
module tb_seg7_scan_mux;

   localparam int R  = 4;
   localparam int BF = 2;
   localparam int BC = 1;

   logic        clk_100MHz;
   logic        reset;
   logic        enable;
   logic [55:0] seg7_in;
   logic [7:0]  blink_mask;
   logic [7:0]  dp_mask;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_start;

   int checks   = 0;
   int failures = 0;

   seg7_scan_mux #(
      .REFRESH_DIV (R),
      .BLINK_FRAMES(BF),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .enable     (enable),
      .seg7_in    (seg7_in),
      .blink_mask (blink_mask),
      .dp_mask    (dp_mask),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_start(frame_start)
   );

   initial begin
      clk_100MHz = 1'b0;
      forever #5 clk_100MHz = ~clk_100MHz;
   end

   // p = number of non-reset edges since reset; everything follows from it.
   function automatic void model(input int p, input logic en, input logic [55:0] s,
                                 input logic [7:0] bm, input logic [7:0] dm,
                                 output logic [7:0] e_an, output logic [6:0] e_seg,
                                 output logic e_dp, output logic e_fs);
      int  slot;
      int  idx;
      int  frame;
      bit  phase;
      bit  blank;
      bit  hid;
      slot  = p % R;
      idx   = (p / R) % 8;
      frame = p / (8 * R);
      phase = ((frame / BF) % 2) == 1;
      blank = 1'b0;
`ifdef SEG7_GHOST_BLANK_EN
      blank = (slot < BC);
`endif
      hid  = phase && bm[idx];
      e_fs = (p > 0) && ((p % (8 * R)) == 0);
      if (!en || blank) begin
         e_an  = 8'hFF;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
      end else begin
         e_an  = ~(8'd1 << idx);
         e_seg = hid ? 7'h7F : s[7*idx +: 7];
         e_dp  = !(dm[idx] && !hid);
      end
   endfunction

   int          p_cnt = 0;
   bit          valid = 1'b0;
   logic [7:0]  x_an;
   logic [6:0]  x_seg;
   logic        x_dp;
   logic        x_fs;

   always @(posedge clk_100MHz) begin
      if (reset) begin
         x_an  = 8'hFF;
         x_seg = 7'h7F;
         x_dp  = 1'b1;
         x_fs  = 1'b0;
         p_cnt = 0;
         valid = 1'b1;
      end else begin
         model(p_cnt, enable, seg7_in, blink_mask, dp_mask, x_an, x_seg, x_dp, x_fs);
         p_cnt = p_cnt + 1;
      end
      #1;
      if (valid) begin
         checks = checks + 1;
         if (an !== x_an || seg !== x_seg || dp !== x_dp || frame_start !== x_fs) begin
            failures = failures + 1;
            $display("FAIL model t=%0t an=%h/%h seg=%h/%h dp=%b/%b fs=%b/%b (actual/required)",
                     $time, an, x_an, seg, x_seg, dp, x_dp, frame_start, x_fs);
         end
      end
   end

   task automatic pin(input string name, input logic [7:0] act, input logic [7:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_100MHz);
      #2;
   endtask

   logic [63:0] rnd;

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      seg7_in    = '0;
      blink_mask = 8'h00;
      dp_mask    = 8'h00;
      step(3);
      pin("reset_an", an, 8'hFF);
      pin("reset_seg", {1'b0, seg}, 8'h7F);

      reset   = 1'b0;
      enable  = 1'b1;
      seg7_in = {7'h47, 7'h46, 7'h45, 7'h44, 7'h43, 7'h42, 7'h41, 7'h40};
      step(1);
      pin("scan_d0_an", an, 8'hFE);
      pin("scan_d0_seg", {1'b0, seg}, 8'h40);
      pin("scan_first_fs", {7'b0, frame_start}, 8'h00);
      step(4);
      pin("scan_d1_an", an, 8'hFD);
      pin("scan_d1_seg", {1'b0, seg}, 8'h41);
      step(24);
      pin("scan_d7_an", an, 8'h7F);
      pin("scan_d7_seg", {1'b0, seg}, 8'h47);
      step(3);
      pin("scan_d7_last_fs", {7'b0, frame_start}, 8'h00);
      step(1);
      pin("scan_wrap_an", an, 8'hFE);
      pin("scan_wrap_fs", {7'b0, frame_start}, 8'h01);

      blink_mask = 8'h04;
      step(8);
      pin("blink_f1_seg", {1'b0, seg}, 8'h42);
      pin("blink_f1_an", an, 8'hFB);
      step(32);
      pin("blink_f2_seg", {1'b0, seg}, 8'h7F);
      pin("blink_f2_an", an, 8'hFB);
      step(4);
      pin("blink_f2_d3_seg", {1'b0, seg}, 8'h43);
      step(60);
      pin("blink_f4_seg", {1'b0, seg}, 8'h42);

      dp_mask    = 8'h81;
      blink_mask = 8'h80;
      step(52);
      pin("dp_d7_ph0", {7'b0, dp}, 8'h00);
      step(4);
      pin("dp_d0_ph1", {7'b0, dp}, 8'h00);
      step(28);
      pin("dp_d7_ph1", {7'b0, dp}, 8'h01);
      pin("seg_d7_ph1", {1'b0, seg}, 8'h7F);
      step(4);
      pin("dp_d0_f7", {7'b0, dp}, 8'h00);

      step(45);
      enable = 1'b0;
      step(1);
      pin("en_off_first", an, 8'hFF);
      step(9);
      pin("en_off_last", an, 8'hFF);
      enable = 1'b1;
      step(1);
      pin("en_resume_d6", an, 8'hBF);
      step(8);
      pin("en_fs_cadence", {7'b0, frame_start}, 8'h01);

      step(56);
      reset      = 1'b1;
      blink_mask = 8'h01;
      step(1);
      pin("midrst_an", an, 8'hFF);
      pin("midrst_seg", {1'b0, seg}, 8'h7F);
      pin("midrst_dp", {7'b0, dp}, 8'h01);
      step(1);
      reset = 1'b0;
      step(1);
      pin("midrst_d0_an", an, 8'hFE);
      pin("midrst_phase0_seg", {1'b0, seg}, 8'h40);
      step(3);
      pin("midrst_slot_full", an, 8'hFE);
      step(1);
      pin("midrst_d1_an", an, 8'hFD);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(7) == 0) begin
            rnd        = {$urandom(), $urandom()};
            seg7_in    = rnd[55:0];
            blink_mask = rnd[63:56];
            dp_mask    = 8'($urandom());
         end
         enable = ($urandom_range(9) != 0);
         reset  = ($urandom_range(299) == 0);
         step(1);
      end
      reset  = 1'b0;
      enable = 1'b1;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
